// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer.
// Holds the PLL in reset, waits for a filtered lock and then releases the
// downstream reset. A lock that never settles is retried a limited number
// of times before the block parks in FAIL. A lock loss while running
// restarts the sequence.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RESET     | pll_rst high for RST_CYCLES cycles
// WAIT_LOCK | pll_rst low, qualifying lock against the filter and timeout
// RUN       | locked, downstream reset released
// FAIL      | retries exhausted, PLL held in reset until soft_rst_req/rst_n
module pll_rst_ctrl #(
    parameter int unsigned RST_CYCLES   = 64,
    parameter int unsigned LOCK_FILTER  = 16,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       lock_lost,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [1:0] state
);

    localparam logic [1:0] ST_RESET     = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_FAIL      = 2'd3;

    // Terminal values: each decision fires on the last counted cycle so the
    // counters never step past their limit.
    localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
    localparam logic [15:0] FILT_LAST  = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] TMO_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]  RETRY_MAX  = 2'(MAX_RETRY);

    logic        lock_meta_q;
    logic        lock_s_q;

    logic [1:0]  state_q,     state_d;
    logic [15:0] rst_cnt_q,   rst_cnt_d;
    logic [15:0] filt_cnt_q,  filt_cnt_d;
    logic [15:0] tmo_cnt_q,   tmo_cnt_d;
    logic [1:0]  retry_q,     retry_d;
    logic [7:0]  loss_q,      loss_d;
    logic        lock_lost_q, lock_lost_d;
    logic        pll_rst_q,   pll_rst_d;
    logic        sys_rst_n_q, sys_rst_n_d;
    logic        fail_q,      fail_d;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state, counter and output decode; counters drop to zero whenever
    // the state is left, so every WAIT_LOCK/RESET entry starts clean.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = 16'd0;
        filt_cnt_d  = 16'd0;
        tmo_cnt_d   = 16'd0;
        retry_d     = retry_q;
        loss_d      = loss_q;
        lock_lost_d = 1'b0;

        if (soft_rst_req) begin
            state_d = ST_RESET;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 16'd1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Filter completion is tested first so it wins a tie
                    // with the timeout.
                    if (lock_s_q && (filt_cnt_q == FILT_LAST)) begin
                        state_d = ST_RUN;
                        retry_d = 2'd0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RESET;
                            retry_d = retry_q + 2'd1;
                        end
                    end else begin
                        filt_cnt_d = lock_s_q ? (filt_cnt_q + 16'd1) : 16'd0;
                        tmo_cnt_d  = tmo_cnt_q + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        state_d     = ST_RESET;
                        lock_lost_d = 1'b1;
                        if (loss_q != 8'hFF) begin
                            loss_d = loss_q + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end

        // Outputs follow the state being entered so they line up with it.
        pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAIL);
        sys_rst_n_d = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    // State, counter and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            rst_cnt_q   <= 16'd0;
            filt_cnt_q  <= 16'd0;
            tmo_cnt_q   <= 16'd0;
            retry_q     <= 2'd0;
            loss_q      <= 8'd0;
            lock_lost_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            lock_lost_q <= lock_lost_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign lock_lost = lock_lost_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed bench for pll_rst_ctrl with RST_CYCLES=4, LOCK_FILTER=3,
// LOCK_TIMEOUT=20, MAX_RETRY=2. Expected output snapshots are queued as each
// step is driven and popped once the DUT has had the cycles to respond.
module tb_pll_rst_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_FILTER  = 3;
    localparam int LOCK_TIMEOUT = 20;
    localparam int MAX_RETRY    = 2;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FAIL  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       soft_rst_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_lost;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    pll_rst_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_FILTER (LOCK_FILTER),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .soft_rst_req(soft_rst_req),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .lock_lost   (lock_lost),
        .fail        (fail),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt),
        .state       (state)
    );

    // Snapshot layout: {state, pll_rst, sys_rst_n, lock_lost, fail, retry, loss}
    function automatic logic [15:0] ev(input logic [1:0] st, input logic [1:0] rt,
                                       input logic [7:0] ls, input logic ll);
        logic pr, sr, fl;
        pr = (st == S_RESET) || (st == S_FAIL);
        sr = (st == S_RUN);
        fl = (st == S_FAIL);
        return {st, pr, sr, ll, fl, rt, ls};
    endfunction

    function automatic logic [15:0] obs();
        return {state, pll_rst, sys_rst_n, lock_lost, fail, retry_cnt, loss_cnt};
    endfunction

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_pop();
        exp_t        e;
        logic [15:0] o;
        e = sb_q.pop_front();
        o = obs();
        checks++;
        assert (o === e.v)
        else begin
            errors++;
            $error("FAIL %s: observed %04h expected %04h", e.tag, o, e.v);
        end
    endtask

    task automatic expect_at(input string tag, input int n, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb_q.push_back(e);
        tk(n);
        sb_pop();
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (state !== S_RUN && n < 60) begin
            tk(1);
            n++;
        end
        checks++;
        assert (state === S_RUN)
        else begin
            errors++;
            $error("FAIL wait_run: observed state %0d expected %0d", state, S_RUN);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        pll_lock     = 1'b0;
        soft_rst_req = 1'b0;
        tk(3);
        expect_at("reset_vals", 0, ev(S_RESET, 2'd0, 8'd0, 1'b0));

        // Release just after an edge; that edge counts as edge 0.
        rst_n = 1'b1;
        expect_at("rst_hold",   3, ev(S_RESET, 2'd0, 8'd0, 1'b0));
        expect_at("wait_entry", 1, ev(S_WAIT,  2'd0, 8'd0, 1'b0));

        // Lock rises as the PLL leaves reset: 2 sync + 3 filter -> RUN at edge 9.
        pll_lock = 1'b1;
        expect_at("filter_pending", 4, ev(S_WAIT, 2'd0, 8'd0, 1'b0));
        expect_at("run_entry",      1, ev(S_RUN,  2'd0, 8'd0, 1'b0));

        // One-cycle lock drop in RUN.
        pll_lock = 1'b0;
        tk(1);
        pll_lock = 1'b1;
        expect_at("loss_sync_lag",   1, ev(S_RUN,   2'd0, 8'd0, 1'b0));
        expect_at("lock_lost_pulse", 1, ev(S_RESET, 2'd0, 8'd1, 1'b1));
        expect_at("lock_lost_clear", 1, ev(S_RESET, 2'd0, 8'd1, 1'b0));
        expect_at("rerst_hold",      2, ev(S_RESET, 2'd0, 8'd1, 1'b0));
        expect_at("rerst_end",       1, ev(S_WAIT,  2'd0, 8'd1, 1'b0));
        expect_at("relock_run",      3, ev(S_RUN,   2'd0, 8'd1, 1'b0));

        // Soft reset from RUN: no lock_lost, loss_cnt unchanged.
        soft_rst_req = 1'b1;
        tk(1);
        soft_rst_req = 1'b0;
        expect_at("soft_in_run", 0, ev(S_RESET, 2'd0, 8'd1, 1'b0));
        expect_at("pre_filter_done", 6, ev(S_WAIT, 2'd0, 8'd1, 1'b0));

        // Soft reset on the edge where the filter would complete.
        soft_rst_req = 1'b1;
        tk(1);
        soft_rst_req = 1'b0;
        expect_at("soft_beats_filter", 0, ev(S_RESET, 2'd0, 8'd1, 1'b0));

        // Soft reset mid-RESET restarts the count; lock now stuck low.
        expect_at("rst_mid", 2, ev(S_RESET, 2'd0, 8'd1, 1'b0));
        soft_rst_req = 1'b1;
        pll_lock     = 1'b0;
        tk(1);
        soft_rst_req = 1'b0;
        expect_at("rst_restart_hold", 3, ev(S_RESET, 2'd0, 8'd1, 1'b0));
        expect_at("rst_restart_end",  1, ev(S_WAIT,  2'd0, 8'd1, 1'b0));

        // Three timed-out attempts, then FAIL.
        expect_at("tmo1_pending", 19, ev(S_WAIT,  2'd0, 8'd1, 1'b0));
        expect_at("tmo1",          1, ev(S_RESET, 2'd1, 8'd1, 1'b0));
        expect_at("attempt2_wait", 4, ev(S_WAIT,  2'd1, 8'd1, 1'b0));
        expect_at("tmo2_pending", 19, ev(S_WAIT,  2'd1, 8'd1, 1'b0));
        expect_at("tmo2",          1, ev(S_RESET, 2'd2, 8'd1, 1'b0));
        expect_at("attempt3_wait", 4, ev(S_WAIT,  2'd2, 8'd1, 1'b0));
        expect_at("tmo3_pending", 19, ev(S_WAIT,  2'd2, 8'd1, 1'b0));
        expect_at("fail_entry",    1, ev(S_FAIL,  2'd2, 8'd1, 1'b0));
        expect_at("fail_hold",    10, ev(S_FAIL,  2'd2, 8'd1, 1'b0));

        // Soft reset out of FAIL, then a 1,1,0 lock pattern that never qualifies.
        soft_rst_req = 1'b1;
        tk(1);
        soft_rst_req = 1'b0;
        expect_at("soft_from_fail", 0, ev(S_RESET, 2'd0, 8'd1, 1'b0));
        for (int i = 0; i < 24; i++) begin
            logic [15:0] v;
            pll_lock = ((i % 3) != 2);
            if (i + 1 < RST_CYCLES)
                v = ev(S_RESET, 2'd0, 8'd1, 1'b0);
            else if (i + 1 < RST_CYCLES + LOCK_TIMEOUT)
                v = ev(S_WAIT, 2'd0, 8'd1, 1'b0);
            else
                v = ev(S_RESET, 2'd1, 8'd1, 1'b0);
            expect_at("toggle_no_run", 1, v);
        end

        // Filter completes on the very cycle the timeout expires.
        pll_lock = 1'b0;
        expect_at("tie_wait_entry", 4, ev(S_WAIT, 2'd1, 8'd1, 1'b0));
        tk(15);
        pll_lock = 1'b1;
        expect_at("tie_pending",     4, ev(S_WAIT, 2'd1, 8'd1, 1'b0));
        expect_at("filter_wins_tie", 1, ev(S_RUN,  2'd0, 8'd1, 1'b0));

        // Repeated lock losses until loss_cnt saturates.
        for (int k = 2; k <= 257; k++) begin
            wait_run();
            pll_lock = 1'b0;
            tk(1);
            pll_lock = 1'b1;
            tk(1);
            expect_at("loss_sat_step", 1,
                      ev(S_RESET, 2'd0, (k > 255) ? 8'd255 : 8'(k), 1'b1));
        end
        expect_at("loss_sat_hold", 1, ev(S_RESET, 2'd0, 8'd255, 1'b0));

        // Asynchronous reset in RUN takes effect without a clock edge.
        wait_run();
        #2;
        rst_n = 1'b0;
        #1;
        expect_at("async_abort", 0, ev(S_RESET, 2'd0, 8'd0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_at("rel_hold", 3, ev(S_RESET, 2'd0, 8'd0, 1'b0));
        expect_at("rel_wait", 1, ev(S_WAIT,  2'd0, 8'd0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_rst_ctrl.md
PLL_RST_CTRL -- requirements
Module: pll_rst_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 64: cycles pll_rst is held high per reset attempt (legal range 1..65535).
REQ-002 Parameter LOCK_FILTER, default 16: consecutive synchronized lock-high cycles required before lock is accepted (legal range 1..65535).
REQ-003 Parameter LOCK_TIMEOUT, default 50000: maximum cycles in WAIT_LOCK before an attempt fails (legal range 2..65535).
REQ-004 Parameter MAX_RETRY, default 3: timeout retries before FAIL (legal range 0..3).
REQ-005 clk  input  1  free-running PLL reference clock (the PLL input clock); sole clock of the block.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 pll_lock  input  1  raw lock from PLL; asynchronous to clk.
REQ-008 soft_rst_req  input  1  single-cycle request to restart the PLL sequence.
REQ-009 pll_rst  output  1  active-high reset to the PLL.
REQ-010 sys_rst_n  output  1  active-low reset for logic clocked by PLL outputs; high only in RUN.
REQ-011 lock_lost  output  1  one-cycle pulse on loss of lock while in RUN.
REQ-012 fail  output  1  high while in FAIL.
REQ-013 retry_cnt  output  2  timeouts counted in the current sequence.
REQ-014 loss_cnt  output  8  total lock losses since rst_n; saturates at 255.
REQ-015 state  output  2  RESET=0, WAIT_LOCK=1, RUN=2, FAIL=3.

Function
REQ-016 pll_lock SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s only.
REQ-017 All outputs SHALL be registered; they reflect the state entered at the same clock edge.
REQ-018 RESET: pll_rst=1, sys_rst_n=0; cycle counter runs 0..RST_CYCLES-1, then state goes to WAIT_LOCK; pll_rst is high for exactly RST_CYCLES cycles.
REQ-019 WAIT_LOCK: pll_rst=0, sys_rst_n=0; filter counter increments when lock_s=1 and clears when lock_s=0; timeout counter increments every cycle.
REQ-020 WAIT_LOCK: when the filter count reaches LOCK_FILTER, state SHALL go to RUN and retry_cnt SHALL clear to 0.
REQ-021 WAIT_LOCK: when the timeout count reaches LOCK_TIMEOUT with the filter not complete, and retry_cnt<MAX_RETRY, retry_cnt SHALL increment and state SHALL go to RESET.
REQ-022 WAIT_LOCK: on timeout with retry_cnt==MAX_RETRY, state SHALL go to FAIL and retry_cnt SHALL hold.
REQ-023 If filter completion and timeout occur on the same cycle, filter completion SHALL win.
REQ-024 RUN: pll_rst=0, sys_rst_n=1; lock_s=0 SHALL cause lock_lost=1 for one cycle, loss_cnt+1 (saturating), state RESET, sys_rst_n=0 on the same edge.
REQ-025 FAIL: pll_rst=1, sys_rst_n=0, fail=1; the block SHALL stay in FAIL until soft_rst_req or rst_n.
REQ-026 soft_rst_req=1 in any state SHALL force RESET, restart the RST_CYCLES count, and clear retry_cnt.
REQ-027 soft_rst_req SHALL take priority over every other transition, and SHALL NOT pulse lock_lost or change loss_cnt.
REQ-028 Filter and timeout counters SHALL clear on every entry to WAIT_LOCK; all counters are 16 bits wide and SHALL never wrap.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: state=RESET, pll_rst=1, sys_rst_n=0, lock_lost=0, fail=0, retry_cnt=0, loss_cnt=0, all counters 0, and synchronizer flops 0.
REQ-030 After rst_n deasserts, the first RESET count SHALL start on the first clk edge.
REQ-031 rst_n asserted mid-sequence (any state) SHALL abort that sequence immediately.

Verification (RST_CYCLES=4, LOCK_FILTER=3, LOCK_TIMEOUT=20, MAX_RETRY=2)
REQ-032 Lock held at 1 from reset -> pll_rst high 4 cycles; RUN and sys_rst_n=1 at 4+2+3 cycles after reset release; retry_cnt=0.
REQ-033 Lock stuck at 0 -> three attempts (retry_cnt 0,1,2); then state=3, fail=1, pll_rst=1; soft_rst_req -> RESET with retry_cnt=0.
REQ-034 In RUN, drop pll_lock for 1 cycle -> lock_lost single pulse 2-3 cycles later, loss_cnt=1, sys_rst_n=0, and a new RESET of 4 cycles.
REQ-035 Lock toggling 1,1,0,1,1,0 repeatedly -> no RUN, timeout after 20 cycles, and retry_cnt increments.
REQ-036 soft_rst_req on the same cycle as filter completion -> state RESET, not RUN; lock_lost=0; loss_cnt unchanged.
REQ-037 256 forced lock losses -> loss_cnt holds at 255.
